// File: rtl/chan_stream_serializer_if.sv
// Stream bundle for chan_stream_serializer: packed multi-channel pixel input side
// and single-word channel stream output side.
interface chan_stream_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         valid_in;
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic                         ready_in;
    logic [DATA_WIDTH-1:0]        data_out;
    logic [CW-1:0]                ch_out;
    logic                         valid_out;
    logic                         ready_out;
    logic                         last_row;
    logic                         last_frame;

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, data_out, ch_out, valid_out, last_row, last_frame
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, data_out, ch_out, valid_out, last_row, last_frame
    );
endinterface

// File: rtl/chan_stream_serializer.sv
// Buffers NUM_CH-channel pixels in a small FIFO and replays them one channel per
// cycle, tagging row/frame ends and stopping with a done pulse after NUM_IMG frames.
module chan_stream_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int WIDTH      = 224,
    parameter int HEIGHT     = 224,
    parameter int NUM_IMG    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    chan_stream_serializer_if.slave  bus,
    output logic                     done,
    output logic                     err
);
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IMG_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

    typedef enum logic {
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CW-1:0]    ch_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [IMG_W-1:0] img_q;
    logic             done_q, err_q;

    logic full, empty, in_run, ready_int, valid_int;
    logic push, accept, pop, frame_end, final_word;
    logic last_ch, last_col, last_row_idx, last_img;
    logic [NUM_CH*DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]        data_word;

    // Handshakes are suppressed while reset is held so nothing moves in the reset cycle.
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign in_run    = !resetn && (state_q == RUN);
    assign ready_int = in_run && !full;
    assign valid_int = in_run && !empty;

    assign push         = bus.valid_in && ready_int;
    assign accept       = valid_int && bus.ready_out;
    assign last_ch      = (ch_q == CW'(NUM_CH - 1));
    assign last_col     = (col_q == COL_W'(WIDTH - 1));
    assign last_row_idx = (row_q == ROW_W'(HEIGHT - 1));
    assign last_img     = (img_q == IMG_W'(NUM_IMG - 1));
    assign pop          = accept && last_ch;
    assign frame_end    = pop && last_col && last_row_idx;
    assign final_word   = frame_end && last_img;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (final_word) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ch_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            img_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            // Position counters cascade: channel -> column -> row -> image.
            if (accept) begin
                ch_q <= last_ch ? '0 : ch_q + CW'(1);
            end
            if (pop) begin
                col_q <= last_col ? '0 : col_q + COL_W'(1);
                if (last_col) begin
                    row_q <= last_row_idx ? '0 : row_q + ROW_W'(1);
                end
            end
            if (frame_end) begin
                img_q <= last_img ? '0 : img_q + IMG_W'(1);
            end

            done_q <= final_word;
            if (state_q == DONE && bus.valid_in) begin
                err_q <= 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr_q];

    always_comb begin
        data_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CW'(c)) begin
                data_word = head[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.ready_in   = ready_int;
    assign bus.valid_out  = valid_int;
    assign bus.data_out   = valid_int ? data_word : '0;
    assign bus.ch_out     = resetn ? '0 : ch_q;
    assign bus.last_row   = valid_int && last_ch && last_col;
    assign bus.last_frame = valid_int && last_ch && last_col && last_row_idx;
    assign done           = done_q && !resetn;
    assign err            = err_q && !resetn;
endmodule

// File: tb/tb_chan_stream_serializer.sv
// Self-checking bench for chan_stream_serializer: a small 3-channel 2x2 instance
// driven from a vector table and hand sequences, and a 4-channel 3x2x2 instance
// driven randomly against an index-arithmetic reference model.
module tb_chan_stream_serializer;
    localparam int DW_A = 32, NC_A = 3;
    localparam int DW_B = 16, NC_B = 4, W_B = 3, H_B = 2, IMG_B = 2, DEPTH_B = 4;
    localparam int TOTAL_PIX_B   = W_B * H_B * IMG_B;
    localparam int TOTAL_WORDS_B = TOTAL_PIX_B * NC_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, done_a, err_a, done_b, err_b;
    int checks = 0;
    int failures = 0;

    chan_stream_serializer_if #(.DATA_WIDTH(DW_A), .NUM_CH(NC_A)) bus_a ();
    chan_stream_serializer_if #(.DATA_WIDTH(DW_B), .NUM_CH(NC_B)) bus_b ();

    chan_stream_serializer #(
        .DATA_WIDTH(DW_A), .NUM_CH(NC_A), .WIDTH(2), .HEIGHT(2),
        .NUM_IMG(1), .FIFO_DEPTH(2)
    ) dut_a (
        .clk(clk), .resetn(rst_a), .bus(bus_a), .done(done_a), .err(err_a)
    );

    chan_stream_serializer #(
        .DATA_WIDTH(DW_B), .NUM_CH(NC_B), .WIDTH(W_B), .HEIGHT(H_B),
        .NUM_IMG(IMG_B), .FIFO_DEPTH(DEPTH_B)
    ) dut_b (
        .clk(clk), .resetn(rst_b), .bus(bus_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic vin;
        int   pix;
        logic rdy;
        logic e_rin;
        logic e_vout;
        int   e_data;
        int   e_ch;
        logic e_lrow;
        logic e_lframe;
        logic e_done;
        logic e_err;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic vin, input int pix, input logic rdy,
                                input logic e_rin, input logic e_vout, input int e_data,
                                input int e_ch, input logic e_lrow, input logic e_lframe,
                                input logic e_done, input logic e_err);
        vec_t v;
        v.vin = vin;       v.pix = pix;         v.rdy = rdy;
        v.e_rin = e_rin;   v.e_vout = e_vout;   v.e_data = e_data;
        v.e_ch = e_ch;     v.e_lrow = e_lrow;   v.e_lframe = e_lframe;
        v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    // Channel c of pixel p carries 10*p + c.
    function automatic logic [NC_A*DW_A-1:0] pixel_a(input int p);
        logic [NC_A*DW_A-1:0] r;
        for (int c = 0; c < NC_A; c++) r[c*DW_A +: DW_A] = DW_A'(10 * p + c);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus_a.valid_in  = v.vin;
        bus_a.data_in   = pixel_a(v.pix);
        bus_a.ready_out = v.rdy;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        checkOutput($sformatf("vec%0d ready_in", idx),   64'(bus_a.ready_in),   64'(v.e_rin));
        checkOutput($sformatf("vec%0d valid_out", idx),  64'(bus_a.valid_out),  64'(v.e_vout));
        checkOutput($sformatf("vec%0d data_out", idx),   64'(bus_a.data_out),   64'(v.e_data));
        checkOutput($sformatf("vec%0d ch_out", idx),     64'(bus_a.ch_out),     64'(v.e_ch));
        checkOutput($sformatf("vec%0d last_row", idx),   64'(bus_a.last_row),   64'(v.e_lrow));
        checkOutput($sformatf("vec%0d last_frame", idx), 64'(bus_a.last_frame), 64'(v.e_lframe));
        checkOutput($sformatf("vec%0d done", idx),       64'(done_a),           64'(v.e_done));
        checkOutput($sformatf("vec%0d err", idx),        64'(err_a),            64'(v.e_err));
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        bus_a.valid_in  = 1'b0;
        bus_a.ready_out = 1'b0;
        bus_a.data_in   = '0;
        #1;
        checkOutput("a reset ready_in",  64'(bus_a.ready_in),  64'(0));
        checkOutput("a reset valid_out", 64'(bus_a.valid_out), 64'(0));
        checkOutput("a reset data_out",  64'(bus_a.data_out),  64'(0));
        checkOutput("a reset ch_out",    64'(bus_a.ch_out),    64'(0));
        checkOutput("a reset done",      64'(done_a),          64'(0));
        checkOutput("a reset err",       64'(err_a),           64'(0));
        step();
        rst_a = 1'b0;
    endtask

    // Streams pixels base.. with ready_out=1 until stop_words words are accepted.
    task automatic stream_a(input int base, input int npix, input int stop_words, input string tag);
        int pushed = 0;
        int words = 0;
        for (int cyc = 0; cyc < 200 && words < stop_words; cyc++) begin
            bus_a.valid_in  = (pushed < npix);
            bus_a.data_in   = pixel_a(base + pushed);
            bus_a.ready_out = 1'b1;
            #1;
            if (bus_a.valid_in && bus_a.ready_in) pushed++;
            if (bus_a.valid_out) begin
                int p = words / NC_A;
                int c = words % NC_A;
                checkOutput({tag, " data_out"},   64'(bus_a.data_out),   64'(10 * (base + p) + c));
                checkOutput({tag, " ch_out"},     64'(bus_a.ch_out),     64'(c));
                checkOutput({tag, " last_row"},   64'(bus_a.last_row),   64'(c == 2 && p % 2 == 1));
                checkOutput({tag, " last_frame"}, 64'(bus_a.last_frame), 64'(c == 2 && p % 4 == 3));
                words++;
            end
            step();
        end
        bus_a.valid_in = 1'b0;
        checkOutput({tag, " words accepted"}, 64'(words), 64'(stop_words));
    endtask

    task automatic run_random(input int iter);
        logic [NC_B*DW_B-1:0] pixq[$];
        int  pushed = 0, acc = 0, lf_seen = 0, done_seen = 0, tail = 0;
        bit  done_exp = 0, done_next = 0;
        rst_b = 1'b1;
        bus_b.valid_in  = 1'b0;
        bus_b.ready_out = 1'b0;
        bus_b.data_in   = '0;
        #1;
        checkOutput("b reset ready_in",  64'(bus_b.ready_in),  64'(0));
        checkOutput("b reset valid_out", 64'(bus_b.valid_out), 64'(0));
        step();
        rst_b = 1'b0;
        for (int cyc = 0; cyc < 2000 && tail < 4; cyc++) begin
            bit fin, e_vout, e_rin, e_lrow, e_lframe;
            int occ, p, c;
            logic [63:0] e_data;
            logic [NC_B*DW_B-1:0] hp;
            bus_b.valid_in  = (pushed < TOTAL_PIX_B) && ($urandom_range(0, 3) != 0);
            bus_b.data_in   = {$urandom(), $urandom()};
            bus_b.ready_out = ($urandom_range(0, 3) != 0);
            #1;
            fin    = (acc >= TOTAL_WORDS_B);
            occ    = pushed - acc / NC_B;
            e_vout = !fin && occ > 0;
            e_rin  = !fin && occ < DEPTH_B;
            p = acc / NC_B;
            c = acc % NC_B;
            e_data = '0; e_lrow = 0; e_lframe = 0;
            if (e_vout) begin
                hp       = pixq[p];
                e_data   = 64'(hp[c*DW_B +: DW_B]);
                e_lrow   = (c == NC_B - 1) && (p % W_B == W_B - 1);
                e_lframe = e_lrow && ((p / W_B) % H_B == H_B - 1);
            end
            checkOutput($sformatf("rnd%0d ready_in", iter),   64'(bus_b.ready_in),   64'(e_rin));
            checkOutput($sformatf("rnd%0d valid_out", iter),  64'(bus_b.valid_out),  64'(e_vout));
            checkOutput($sformatf("rnd%0d data_out", iter),   64'(bus_b.data_out),   e_data);
            checkOutput($sformatf("rnd%0d ch_out", iter),     64'(bus_b.ch_out),     64'(c));
            checkOutput($sformatf("rnd%0d last_row", iter),   64'(bus_b.last_row),   64'(e_lrow));
            checkOutput($sformatf("rnd%0d last_frame", iter), 64'(bus_b.last_frame), 64'(e_lframe));
            checkOutput($sformatf("rnd%0d done", iter),       64'(done_b),           64'(done_exp));
            checkOutput($sformatf("rnd%0d err", iter),        64'(err_b),            64'(0));
            if (bus_b.valid_out && bus_b.ready_out && bus_b.last_frame) lf_seen++;
            if (done_b) done_seen++;
            if (bus_b.valid_in && e_rin) begin
                pixq.push_back(bus_b.data_in);
                pushed++;
            end
            done_next = e_vout && bus_b.ready_out && (acc + 1 == TOTAL_WORDS_B);
            if (e_vout && bus_b.ready_out) acc++;
            done_exp = done_next;
            if (fin) tail++;
            step();
        end
        bus_b.valid_in = 1'b0;
        checkOutput($sformatf("rnd%0d words accepted", iter), 64'(acc), 64'(TOTAL_WORDS_B));
        checkOutput($sformatf("rnd%0d last_frame count", iter), 64'(lf_seen), 64'(IMG_B));
        checkOutput($sformatf("rnd%0d done count", iter), 64'(done_seen), 64'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.valid_in = 1'b0; bus_a.ready_out = 1'b0; bus_a.data_in = '0;
        bus_b.valid_in = 1'b0; bus_b.ready_out = 1'b0; bus_b.data_in = '0;

        // Full frame with ready_out=1, FIFO-full refusal with simultaneous pop, done, err.
        vecs[0]  = mk(1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 2, 1, 0, 1,  1, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 2, 1, 0, 1,  2, 2, 0, 0, 0, 0);
        vecs[4]  = mk(1, 2, 1, 1, 1, 10, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 3, 1, 0, 1, 11, 1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 3, 1, 0, 1, 12, 2, 1, 0, 0, 0);
        vecs[7]  = mk(1, 3, 1, 1, 1, 20, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 1, 21, 1, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 1, 22, 2, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 1, 1, 1, 30, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 1, 1, 31, 1, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 1, 1, 32, 2, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        vecs[14] = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[17] = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);

        @(negedge clk);
        reset_a();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            #1;
            check_vec(vecs[i], i);
            step();
        end

        // Backpressure: head held for 5 cycles, third pixel refused, nothing lost.
        reset_a();
        #1;
        checkOutput("err cleared by reset", 64'(err_a), 64'(0));
        bus_a.valid_in = 1'b1; bus_a.data_in = pixel_a(5); bus_a.ready_out = 1'b0;
        #1;
        checkOutput("bp push0 ready_in", 64'(bus_a.ready_in), 64'(1));
        step();
        bus_a.data_in = pixel_a(6);
        #1;
        checkOutput("bp push1 ready_in", 64'(bus_a.ready_in), 64'(1));
        step();
        bus_a.data_in = pixel_a(7);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bp hold ready_in",  64'(bus_a.ready_in),  64'(0));
            checkOutput("bp hold valid_out", 64'(bus_a.valid_out), 64'(1));
            checkOutput("bp hold data_out",  64'(bus_a.data_out),  64'(50));
            checkOutput("bp hold ch_out",    64'(bus_a.ch_out),    64'(0));
            step();
        end
        bus_a.valid_in = 1'b0; bus_a.ready_out = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput("bp drain valid_out", 64'(bus_a.valid_out), 64'(1));
            checkOutput("bp drain data_out",  64'(bus_a.data_out),  64'(10 * (5 + k / 3) + k % 3));
            checkOutput("bp drain ch_out",    64'(bus_a.ch_out),    64'(k % 3));
            checkOutput("bp drain last_row",  64'(bus_a.last_row),  64'(k == 5));
            step();
        end
        #1;
        checkOutput("bp drained valid_out", 64'(bus_a.valid_out), 64'(0));

        // Reset after 5 accepted words aborts the frame; the next frame restarts clean.
        step();
        reset_a();
        stream_a(0, 4, 5, "abort");
        reset_a();
        #1;
        checkOutput("post-abort valid_out", 64'(bus_a.valid_out), 64'(0));
        checkOutput("post-abort ready_in",  64'(bus_a.ready_in),  64'(1));
        checkOutput("post-abort ch_out",    64'(bus_a.ch_out),    64'(0));
        step();
        stream_a(10, 4, 12, "restart");
        #1;
        checkOutput("restart done pulse", 64'(done_a), 64'(1));
        checkOutput("restart ready_in",   64'(bus_a.ready_in), 64'(0));
        step();
        #1;
        checkOutput("restart done cleared", 64'(done_a), 64'(0));

        // Random stream on the two-image instance.
        for (int it = 0; it < 2; it++) run_random(it);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chan_stream_serializer.md
Name: chan_stream_serializer

Overview:
- Synthesizable, parametrised successor to the bench multi-channel frame source.
- Accepts one pixel per transfer on a packed NUM_CH-channel bus and buffers it in a small FIFO.
- Emits the pixel one channel per cycle on a single DATA_WIDTH stream, with ready/valid backpressure and row/frame/image position flags.
- Sits between multi-channel conv/pool block outputs and single-stream consumers (writer, dense/sigmoid stage); ends with a done pulse after NUM_IMG frames.

Parameters:
- DATA_WIDTH, 32, bits per channel word.
- NUM_CH, 8, channels per pixel (>=1).
- WIDTH, 224, pixels per row.
- HEIGHT, 224, rows per frame.
- NUM_IMG, 1, frames to process before done.
- FIFO_DEPTH, 4, pixel-vector FIFO entries (power of 2, >=2).
- CW (local), max(1,$clog2(NUM_CH)), channel index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous, active-high reset; port name kept per codebase convention, asserted = 1.
- valid_in  in  1  input pixel valid.
- data_in  in  NUM_CH*DATA_WIDTH  packed pixel; channel c = data_in[c*DATA_WIDTH +: DATA_WIDTH].
- ready_in  out  1  FIFO can accept a pixel.
- data_out  out  DATA_WIDTH  current channel word.
- ch_out  out  CW  channel index of data_out.
- valid_out  out  1  data_out valid.
- ready_out  in  1  downstream accepts.
- last_row  out  1  data_out is the last channel of the last pixel in a row.
- last_frame  out  1  data_out is the last channel of the last pixel in a frame.
- done  out  1  one-cycle pulse after the final word of image NUM_IMG-1 is accepted.
- err  out  1  sticky; set by valid_in while in state DONE.

Behaviour:
- Reset (resetn=1 at a clock edge):
  - FIFO is emptied; ch, col, row and img counters go to 0; state goes to RUN.
  - Outputs: ready_in=0 during the reset cycle, valid_out=0, done=0, err=0, data_out=0, ch_out=0.
  - Reset asserted mid-frame aborts the frame. No partial output follows.
- Push: a pixel is written when valid_in && ready_in.
  - ready_in = (state==RUN) && !full.
  - There is no same-cycle bypass. When full, a push is refused even if a pop occurs in the same cycle.
- Latency: a pixel pushed at edge t into an empty FIFO gives valid_out=1 with channel 0 in the cycle after t.
- Output: valid_out = (state==RUN) && !empty.
  - data_out = head[ch*DATA_WIDTH +: DATA_WIDTH]; ch_out = ch.
  - data_out is held stable while valid_out && !ready_out.
- Accept: a word is accepted when valid_out && ready_out.
  - ch increments on each accept.
  - On ch==NUM_CH-1: ch wraps to 0, the head is popped, and col increments.
  - col==WIDTH-1 wraps to 0 and increments row.
  - row==HEIGHT-1 wraps to 0 and increments img.
- Flags:
  - last_row = valid_out && ch==NUM_CH-1 && col==WIDTH-1.
  - last_frame = last_row && row==HEIGHT-1.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH)+1.
- State machine:
  - RUN -> DONE on acceptance of the word with last_frame=1 and img==NUM_IMG-1; done=1 in the following cycle only.
  - In DONE: ready_in=0, valid_out=0, and the machine stays until reset.
  - valid_in=1 in DONE sets err, which is held until reset.
- NUM_CH==1: ch stays 0, and every accept pops.

Test Plan:
- Params NUM_CH=3, WIDTH=2, HEIGHT=2, NUM_IMG=1, FIFO_DEPTH=2, ready_out=1. Push 4 pixels with channels {10·p+c}.
  - Required: data_out sequence 0,1,2,10,11,12,20,21,22,30,31,32.
  - Required: ch_out cycles 0,1,2; last_row on words 12 and 32; last_frame on word 32 only; done pulses 1 cycle after 32; then ready_in=0.
- Backpressure: hold ready_out=0 for 5 cycles with a pixel at head.
  - Required: data_out and ch_out stable; valid_out=1.
  - Required: after pushing 2 pixels, ready_in=0; a third valid_in is not accepted, and no data is lost after release.
- Full with simultaneous pop: FIFO full, ready_out=1 on the final channel of the head, valid_in=1.
  - Required: ready_in=0 in that cycle (no bypass); the push succeeds the next cycle.
- NUM_IMG=2: two frames streamed.
  - Required: last_frame twice and done exactly once, after the second frame's last word.
- Reset mid-frame: assert resetn=1 after 5 accepted words.
  - Required: next cycle valid_out=0 and FIFO empty; the following frame restarts at ch_out=0 with col/row at 0.
- Post-done input: valid_in=1 in DONE.
  - Required: err=1 sticky until reset; valid_out stays 0.
